refill_ctrl_two: RTL and testbench

// - Miss/refill controller for a 2-way set-associative cache; sits directly upstream of the 2-way LRU bookkeeping block.
// - Accepts tag-lookup results, picks a victim from the valid/dirty state and the LRU read port, and sequences writeback then fill.
// - Drives the LRU update port on every hit and every install.

---
 rtl/refill_ctrl_two_pkg.sv | 23 ++
 rtl/refill_ctrl_two_victim_sel.sv | 23 ++
 rtl/refill_ctrl_two.sv | 146 ++++++++++++++
 tb/tb_refill_ctrl_two.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/refill_ctrl_two_pkg.sv
// Shared types for the 2-way refill controller: FSM states, way count, latched miss context.
// No logic; no latency; no backpressure.
package refill_ctrl_two_pkg;

    localparam int WAYS     = 2;
    localparam int IDX_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_INSTALL
    } refill_state_e;

    // Miss context held from accept until install.
    typedef struct packed {
        logic [IDX_BITS-1:0] index;
        logic                way;
        logic                write;
    } victim_t;

endpackage

// File: rtl/refill_ctrl_two_victim_sel.sv
// Victim way choice for one set: first invalid way, else the LRU way; flags a dirty victim.
// Purely combinational; no backpressure.
module victim_sel_two
    import refill_ctrl_two_pkg::*;
(
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] dirty,
    input  logic            lru_way,
    output logic            way,
    output logic            needs_wb
);

    always_comb begin
        way = lru_way;
        if (!valid[0]) begin
            way = 1'b0;
        end else if (!valid[1]) begin
            way = 1'b1;
        end
        needs_wb = valid[way] & dirty[way];
    end

endmodule

// File: rtl/refill_ctrl_two.sv
// Miss/refill controller for a 2-way cache; hit resp 1 cycle, clean miss 3, dirty miss 4 (zero-wait).
// Lookups stall (lookup_ready=0) outside IDLE and in the hit resp cycle; REFILL_PERF_CNT_EN adds hit/miss counters.
module refill_ctrl_two
    import refill_ctrl_two_pkg::*;
#(
    parameter int ENTRIES    = 256,
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    output logic                  lookup_ready,
    input  logic [INDEX_BITS-1:0] lookup_index,
    input  logic                  lookup_hit,
    input  logic                  lookup_hit_way,
    input  logic                  lookup_write,
    output logic [INDEX_BITS-1:0] lru_line_selector,
    input  logic                  lru_way,
    output logic                  lru_update,
    output logic                  lru_referenced,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [INDEX_BITS-1:0] wb_index,
    output logic                  wb_way,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [INDEX_BITS-1:0] fill_index,
    output logic                  fill_way,
    input  logic                  fill_done,
    output logic                  resp_valid,
    output logic                  resp_way,
    output logic                  resp_miss
`ifdef REFILL_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    refill_state_e   state_q;
    victim_t         lat_q;
    logic [WAYS-1:0] valid_q [ENTRIES];
    logic [WAYS-1:0] dirty_q [ENTRIES];

    logic accept, hit_acc, miss_acc;
    logic vic_way, vic_wb;

    assign lookup_ready = (state_q == ST_IDLE) && !resp_valid;
    assign accept       = lookup_valid && lookup_ready;
    assign hit_acc      = accept && lookup_hit;
    assign miss_acc     = accept && !lookup_hit;

    victim_sel_two u_victim_sel (
        .valid    (valid_q[lookup_index]),
        .dirty    (dirty_q[lookup_index]),
        .lru_way  (lru_way),
        .way      (vic_way),
        .needs_wb (vic_wb)
    );

    // The LRU port follows the live lookup while idle, then stays on the set being refilled.
    assign lru_line_selector = (state_q == ST_IDLE) ? lookup_index : lat_q.index;
    assign lru_update        = hit_acc || (state_q == ST_INSTALL);
    assign lru_referenced    = hit_acc ? lookup_hit_way : ((state_q == ST_INSTALL) && lat_q.way);

    assign wb_valid   = (state_q == ST_WB);
    assign wb_index   = wb_valid ? lat_q.index : '0;
    assign wb_way     = wb_valid && lat_q.way;
    assign fill_valid = (state_q == ST_FILL_REQ);
    assign fill_index = fill_valid ? lat_q.index : '0;
    assign fill_way   = fill_valid && lat_q.way;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            resp_valid <= 1'b0;
            resp_way   <= 1'b0;
            resp_miss  <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= '0;
                dirty_q[i] <= '0;
            end
        end else begin
            resp_valid <= 1'b0;
            resp_way   <= 1'b0;
            resp_miss  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hit_acc) begin
                        dirty_q[lookup_index][lookup_hit_way] <=
                            dirty_q[lookup_index][lookup_hit_way] | lookup_write;
                        resp_valid <= 1'b1;
                        resp_way   <= lookup_hit_way;
                    end else if (miss_acc) begin
                        lat_q   <= '{index: lookup_index, way: vic_way, write: lookup_write};
                        state_q <= vic_wb ? ST_WB : ST_FILL_REQ;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        dirty_q[lat_q.index][lat_q.way] <= 1'b0;
                        state_q <= ST_FILL_REQ;
                    end
                end
                ST_FILL_REQ: begin
                    if (fill_ready) begin
                        state_q <= ST_FILL_WAIT;
                    end
                end
                ST_FILL_WAIT: begin
                    // Response is registered so it lines up with the INSTALL cycle.
                    if (fill_done) begin
                        state_q    <= ST_INSTALL;
                        resp_valid <= 1'b1;
                        resp_miss  <= 1'b1;
                        resp_way   <= lat_q.way;
                    end
                end
                ST_INSTALL: begin
                    valid_q[lat_q.index][lat_q.way] <= 1'b1;
                    dirty_q[lat_q.index][lat_q.way] <= lat_q.write;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef REFILL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_acc) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_acc) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_refill_ctrl_two.sv
// Directed bench for refill_ctrl_two: reset, hits, clean/dirty misses, stalls, stray fill_done, mid-refill reset.
// Counter checks are compiled only with REFILL_PERF_CNT_EN.
module tb_refill_ctrl_two;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lookup_valid = 1'b0;
    logic       lookup_ready;
    logic [7:0] lookup_index = '0;
    logic       lookup_hit = 1'b0;
    logic       lookup_hit_way = 1'b0;
    logic       lookup_write = 1'b0;
    logic [7:0] lru_line_selector;
    logic       lru_way = 1'b0;
    logic       lru_update;
    logic       lru_referenced;
    logic       wb_valid;
    logic       wb_ready = 1'b0;
    logic [7:0] wb_index;
    logic       wb_way;
    logic       fill_valid;
    logic       fill_ready = 1'b0;
    logic [7:0] fill_index;
    logic       fill_way;
    logic       fill_done = 1'b0;
    logic       resp_valid;
    logic       resp_way;
    logic       resp_miss;
`ifdef REFILL_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    refill_ctrl_two dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_valid      (lookup_valid),
        .lookup_ready      (lookup_ready),
        .lookup_index      (lookup_index),
        .lookup_hit        (lookup_hit),
        .lookup_hit_way    (lookup_hit_way),
        .lookup_write      (lookup_write),
        .lru_line_selector (lru_line_selector),
        .lru_way           (lru_way),
        .lru_update        (lru_update),
        .lru_referenced    (lru_referenced),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_index          (wb_index),
        .wb_way            (wb_way),
        .fill_valid        (fill_valid),
        .fill_ready        (fill_ready),
        .fill_index        (fill_index),
        .fill_way          (fill_way),
        .fill_done         (fill_done),
        .resp_valid        (resp_valid),
        .resp_way          (resp_way),
        .resp_miss         (resp_miss)
`ifdef REFILL_PERF_CNT_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lookup_valid = 1'b0; lookup_index = '0; lookup_hit = 1'b0;
        lookup_hit_way = 1'b0; lookup_write = 1'b0;
        wb_ready = 1'b0; fill_ready = 1'b0; fill_done = 1'b0;
    endtask

    task automatic run_hit(input string tag, input logic [7:0] idx, input logic way, input logic wr);
        next_cycle();
        lookup_valid = 1'b1; lookup_index = idx; lookup_hit = 1'b1;
        lookup_hit_way = way; lookup_write = wr;
        #1;
        check({tag, "_upd"}, 32'(lru_update), 1);
        check({tag, "_ref"}, 32'(lru_referenced), 32'(way));
        next_cycle();
        idle_inputs();
        #1;
        check({tag, "_resp"}, {29'd0, resp_valid, resp_miss, resp_way}, {29'd0, 1'b1, 1'b0, way});
        check({tag, "_rdy_low"}, 32'(lookup_ready), 0);
        next_cycle();
        #1;
        check({tag, "_after"}, {30'd0, resp_valid, lookup_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    // Miss with zero-wait handshakes; checks latency, writeback presence and install outputs.
    task automatic run_miss(input string tag, input logic [7:0] idx, input logic wr, input logic lw,
                            input logic exp_way, input logic exp_wb);
        int   lat;
        logic saw_wb;
        saw_wb = 1'b0;
        next_cycle();
        lookup_valid = 1'b1; lookup_index = idx; lookup_hit = 1'b0; lookup_write = wr;
        lru_way = lw; wb_ready = 1'b1; fill_ready = 1'b1; fill_done = 1'b1;
        #1;
        check({tag, "_acc_rdy"}, 32'(lookup_ready), 1);
        next_cycle();
        lookup_valid = 1'b0; lookup_index = '0;
        lat = 1;
        forever begin
            #1;
            if (resp_valid || lat >= 20) break;
            if (wb_valid) begin
                saw_wb = 1'b1;
                check({tag, "_wb_loc"}, {23'd0, wb_index, wb_way}, {23'd0, idx, exp_way});
            end
            if (fill_valid) check({tag, "_fill_loc"}, {23'd0, fill_index, fill_way}, {23'd0, idx, exp_way});
            next_cycle();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), exp_wb ? 4 : 3);
        check({tag, "_saw_wb"}, 32'(saw_wb), 32'(exp_wb));
        check({tag, "_install"}, {28'd0, resp_miss, resp_way, lru_update, lru_referenced},
              {28'd0, 1'b1, exp_way, 1'b1, exp_way});
        next_cycle();
        idle_inputs();
        #1;
        check({tag, "_back_idle"}, {30'd0, lookup_ready, resp_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin
        // Reset state
        repeat (2) next_cycle();
        #1;
        check("rst_ready", 32'(lookup_ready), 1);
        check("rst_sel", 32'(lru_line_selector), 0);
        check("rst_outs", {25'd0, lru_update, lru_referenced, wb_valid, fill_valid, resp_valid, resp_way, resp_miss}, 0);
        check("rst_locs", {8'd0, wb_index, fill_index, 6'd0, wb_way, fill_way}, 0);
        next_cycle();
        rst = 1'b0;

        // Stray fill_done in IDLE
        fill_done = 1'b1;
        next_cycle();
        fill_done = 1'b0;
        #1;
        check("idle_fd", {29'd0, lookup_ready, fill_valid, resp_valid}, {29'd0, 1'b1, 1'b0, 1'b0});

        // Cold miss idx 5 with stalls; lru_way=1 must not matter since way0 is invalid
        next_cycle();
        lookup_valid = 1'b1; lookup_index = 8'd5; lookup_write = 1'b0; lru_way = 1'b1;
        #1;
        check("cold_sel", 32'(lru_line_selector), 5);
        check("cold_no_upd", 32'(lru_update), 0);
        next_cycle();
        idle_inputs(); lru_way = 1'b1; fill_done = 1'b1;
        #1;
        check("cold_fill", {22'd0, wb_valid, fill_valid, fill_index, fill_way}, {22'd0, 1'b0, 1'b1, 8'd5, 1'b0});
        check("cold_sel_latched", 32'(lru_line_selector), 5);
        next_cycle();
        #1;
        check("fillreq_fd_ignored", {30'd0, fill_valid, resp_valid}, {30'd0, 1'b1, 1'b0});
        fill_done = 1'b0; fill_ready = 1'b1;
        next_cycle();
        fill_ready = 1'b0;
        #1;
        check("fill_wait", {30'd0, fill_valid, resp_valid}, 0);
        fill_done = 1'b1;
        next_cycle();
        fill_done = 1'b0;
        #1;
        check("cold_install", {27'd0, lru_update, lru_referenced, resp_valid, resp_miss, resp_way},
              {27'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        next_cycle();
        #1;
        check("cold_done", {30'd0, lookup_ready, resp_valid}, {30'd0, 1'b1, 1'b0});

        // Second miss fills way1; hits on both ways, way1 written
        run_miss("fill_w1", 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        run_hit("hit_w1_wr", 8'd5, 1'b1, 1'b1);
        run_hit("hit_w0_rd", 8'd5, 1'b0, 1'b0);

        // Full set, LRU=1, way1 dirty: writeback stalled 3 cycles
        next_cycle();
        lookup_valid = 1'b1; lookup_index = 8'd5; lookup_write = 1'b0; lru_way = 1'b1;
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            check("wb_hold", {21'd0, wb_valid, fill_valid, wb_index, wb_way, 1'b0}, {21'd0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0});
            next_cycle();
        end
        wb_ready = 1'b1;
        next_cycle();
        wb_ready = 1'b0;
        #1;
        check("wb_to_fill", {22'd0, wb_valid, fill_valid, fill_index, fill_way}, {22'd0, 1'b0, 1'b1, 8'd5, 1'b1});
        fill_ready = 1'b1;
        next_cycle();
        fill_ready = 1'b0; fill_done = 1'b1;
        next_cycle();
        fill_done = 1'b0;
        #1;
        check("wb_install", {29'd0, resp_valid, resp_miss, resp_way}, {29'd0, 1'b1, 1'b1, 1'b1});

        // Way1 now clean; store-miss installs dirty way0, which a later miss must write back
        run_miss("clean_w1", 8'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        run_miss("store_w0", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_miss("dirty_w0", 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        run_miss("cold_idx9", 8'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        run_hit("hit_idx9", 8'd9, 1'b0, 1'b0);

        // Reset during FILL_WAIT drops the request
        next_cycle();
        lookup_valid = 1'b1; lookup_index = 8'd5; lookup_write = 1'b1; lru_way = 1'b0; fill_ready = 1'b1;
        next_cycle();
        lookup_valid = 1'b0;
        next_cycle();
        fill_ready = 1'b0;
        rst = 1'b1;
        next_cycle();
        #1;
        check("midrst_idle", {29'd0, lookup_ready, resp_valid, fill_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        rst = 1'b0; fill_done = 1'b1;
        next_cycle();
        fill_done = 1'b0;
        #1;
        check("midrst_no_resp", 32'(resp_valid), 0);
        run_miss("post_rst_w0", 8'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        run_miss("post_rst_w1", 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef REFILL_PERF_CNT_EN
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("cnt_rst", hit_count | miss_count, 0);
        run_miss("cnt_m0", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_miss("cnt_m1", 8'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        run_hit("cnt_h0", 8'd3, 1'b0, 1'b0);
        run_hit("cnt_h1", 8'd3, 1'b1, 1'b0);
        run_hit("cnt_h2", 8'd3, 1'b0, 1'b1);
        check("cnt_hits", hit_count, 3);
        check("cnt_misses", miss_count, 2);
        next_cycle();
        dut.hit_count = 32'hFFFF_FFFF;
        run_hit("cnt_wrap_hit", 8'd3, 1'b1, 1'b0);
        check("cnt_wrap", hit_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
